dla_reset_sequencer: RTL and testbench
======================================

// Module: dla_reset_sequencer
// PURPOSE
//  Consumes the synchronized active-low reset from the per-domain reset synchronizer and
//  fans it out as NUM_STAGES staggered, registered stage resets. Enforces a minimum reset
//  hold, releases stages in index order, and reports readiness. Also supports a
//  software-requested soft reset that first drains the datapath (idle handshake, with timeout).
// PARAMETERS
//  NUM_STAGES     4    number of sequenced reset outputs (>=1)
//  HOLD_CYCLES    16   cycles all stages stay in reset after reset/soft-reset entry (>=1)
//  STAGE_GAP      8    cycles between consecutive stage releases (>=1)
//  DRAIN_TIMEOUT  256  max cycles to wait for i_idle during soft-reset drain (>=1)
// PORTS
//  clk              in   1           clock
//  i_sync_resetn    in   1           synchronous active-low reset, already synchronized to clk
//  i_sw_reset_req   in   1           soft-reset request level, sampled only in RUN
//  i_idle           in   1           datapath idle, sampled only in DRAIN
//  o_stage_resetn   out  NUM_STAGES  per-stage active-low sync resets; bit k released k-th
//  o_ready          out  1           all stages out of reset, sequencer in RUN
//  o_drain_req      out  1           asks datapath to stop accepting work and drain
//  o_drain_timeout  out  1           1-cycle pulse: drain abandoned after DRAIN_TIMEOUT
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-low (i_sync_resetn). All outputs registered.
//  - i_sync_resetn=0 at any edge, in any state: state<=HOLD, counter<=0, o_stage_resetn<=0,
//    o_ready<=0, o_drain_req<=0, o_drain_timeout<=0. Overrides every other input.
//  - FSM states: HOLD, RELEASE, RUN, DRAIN.
//  - Define t=0 as the first edge sampling i_sync_resetn=1 (or the soft-reset entry edge).
//  - HOLD: all stage resets low; at edge t=HOLD_CYCLES, o_stage_resetn[0]<=1, go RELEASE.
//  - RELEASE: o_stage_resetn[k] rises at edge HOLD_CYCLES+k*STAGE_GAP; once a bit rises it
//    stays high until the next reset entry. At edge HOLD_CYCLES+NUM_STAGES*STAGE_GAP,
//    o_ready<=1, go RUN. Defaults: stages rise at 16,24,32,40; o_ready at 48.
//  - RUN: i_sw_reset_req=1 at edge e -> o_ready<=0, o_drain_req<=1, go DRAIN. The drain
//    counter clears at e. Stage resets remain high during DRAIN.
//  - DRAIN: first i_idle=1 sampled at edge e+n (n>=1): o_drain_req<=0, o_stage_resetn<=0
//    (all bits, same edge), go HOLD; that edge is the new t=0.
//    If i_idle has not been sampled 1 by edge e+DRAIN_TIMEOUT: same transition at that
//    edge, plus o_drain_timeout<=1 for exactly one cycle.
//    i_idle=1 at the timeout edge counts as idle: no timeout pulse.
//  - i_sw_reset_req is ignored in HOLD/RELEASE/DRAIN, with no queueing. A request still
//    high on return to RUN starts a new drain at the first RUN edge sampling it.
//  - i_idle is ignored outside DRAIN.
//  - Single shared counter, width $clog2(max(HOLD_CYCLES+NUM_STAGES*STAGE_GAP,
//    DRAIN_TIMEOUT)+1). It saturates and never wraps. It clears on every state entry.
//  - Invariant: o_stage_resetn is thermometer-coded (bit k high implies bits <k high).
//    o_ready=1 only when all bits are high.
//  - Elaboration error if any parameter is below its stated minimum.
// TESTING
//  - Power-up: resetn low 5 cycles then high -> all outputs 0 during reset;
//    stage bits rise at 16/24/32/40, o_ready at 48, o_drain_req stays 0.
//  - Reset mid-RELEASE: drop resetn at cycle 30 (stages 0-1 up) -> next edge all outputs 0;
//    after release, full sequence restarts from t=0.
//  - Soft reset with idle: in RUN pulse i_sw_reset_req, i_idle=1 three cycles later ->
//    o_drain_req high 3 cycles, stages all drop together, sequence repeats, no timeout pulse.
//  - Drain timeout: DRAIN_TIMEOUT=256, i_idle held 0 -> at edge e+256 stages drop,
//    o_drain_timeout high exactly 1 cycle, o_ready returns 48 cycles later.
//  - Ignored request: assert i_sw_reset_req during HOLD and RELEASE only, deassert before RUN
//    -> no DRAIN entry, o_drain_req never asserts.
//  - Corner params: NUM_STAGES=1, HOLD_CYCLES=1, STAGE_GAP=1 -> stage0 at edge 1, ready at 2;
//    i_idle=1 exactly at the timeout edge -> no timeout pulse.

Source files
------------

// File: rtl/dla_reset_sequencer.sv
// Staggered per-stage reset fan-out with minimum hold, ordered release and drained soft reset.
module dla_reset_sequencer #(
    parameter int unsigned NUM_STAGES    = 4,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned STAGE_GAP     = 8,
    parameter int unsigned DRAIN_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  i_sync_resetn,
    input  logic                  i_sw_reset_req,
    input  logic                  i_idle,
    output logic [NUM_STAGES-1:0] o_stage_resetn,
    output logic                  o_ready,
    output logic                  o_drain_req,
    output logic                  o_drain_timeout
);

    localparam int unsigned SEQ_LEN = HOLD_CYCLES + NUM_STAGES * STAGE_GAP;
    localparam int unsigned CNT_MAX = (SEQ_LEN > DRAIN_TIMEOUT) ? SEQ_LEN : DRAIN_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Reject parameter values below their minimum at elaboration.
    if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1 || DRAIN_TIMEOUT < 1) begin : g_param_check
        $error("dla_reset_sequencer: all parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]   stage_d;
    logic                    ready_d;
    logic                    drain_req_d;
    logic                    drain_timeout_d;

    // Next-state, counter and output decode. The counter holds the number of edges
    // since t=0 of the current state; an entry edge that is itself t=0 loads 1.
    always_comb begin
        state_d         = state_q;
        cnt_d           = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + CNT_W'(1);
        stage_d         = o_stage_resetn;
        ready_d         = o_ready;
        drain_req_d     = o_drain_req;
        drain_timeout_d = 1'b0;

        case (state_q)
            HOLD: begin
                stage_d     = '0;
                ready_d     = 1'b0;
                drain_req_d = 1'b0;
                if (cnt_q == CNT_W'(HOLD_CYCLES)) begin
                    stage_d = NUM_STAGES'(1);
                    state_d = RELEASE;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE: begin
                for (int unsigned k = 1; k < NUM_STAGES; k++) begin
                    if (cnt_q == CNT_W'(k * STAGE_GAP)) begin
                        stage_d = stage_d | (NUM_STAGES'(1) << k);
                    end
                end
                if (cnt_q == CNT_W'(NUM_STAGES * STAGE_GAP)) begin
                    ready_d = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (i_sw_reset_req) begin
                    ready_d     = 1'b0;
                    drain_req_d = 1'b1;
                    state_d     = DRAIN;
                    cnt_d       = CNT_W'(1);
                end
            end
            DRAIN: begin
                if (i_idle || (cnt_q == CNT_W'(DRAIN_TIMEOUT))) begin
                    drain_req_d     = 1'b0;
                    stage_d         = '0;
                    drain_timeout_d = ~i_idle;
                    state_d         = HOLD;
                    cnt_d           = CNT_W'(1);
                end
            end
            default: begin
                stage_d = '0;
                ready_d = 1'b0;
                state_d = HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!i_sync_resetn) begin
            state_q         <= HOLD;
            cnt_q           <= '0;
            o_stage_resetn  <= '0;
            o_ready         <= 1'b0;
            o_drain_req     <= 1'b0;
            o_drain_timeout <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            o_stage_resetn  <= stage_d;
            o_ready         <= ready_d;
            o_drain_req     <= drain_req_d;
            o_drain_timeout <= drain_timeout_d;
        end
    end

endmodule

// File: tb/tb_dla_reset_sequencer.sv
// Directed self-checking bench: default instance plus a minimum-parameter instance.
module tb_dla_reset_sequencer;

    logic       clk = 1'b0;
    logic       resetn, sw, idle;
    logic [3:0] stage;
    logic       ready, drain, tmo;

    logic       resetn_c, sw_c, idle_c;
    logic [0:0] stage_c;
    logic       ready_c, drain_c, tmo_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dla_reset_sequencer dut (
        .clk             (clk),
        .i_sync_resetn   (resetn),
        .i_sw_reset_req  (sw),
        .i_idle          (idle),
        .o_stage_resetn  (stage),
        .o_ready         (ready),
        .o_drain_req     (drain),
        .o_drain_timeout (tmo)
    );

    dla_reset_sequencer #(
        .NUM_STAGES    (1),
        .HOLD_CYCLES   (1),
        .STAGE_GAP     (1),
        .DRAIN_TIMEOUT (4)
    ) dut_c (
        .clk             (clk),
        .i_sync_resetn   (resetn_c),
        .i_sw_reset_req  (sw_c),
        .i_idle          (idle_c),
        .o_stage_resetn  (stage_c),
        .o_ready         (ready_c),
        .o_drain_req     (drain_c),
        .o_drain_timeout (tmo_c)
    );

    // Single comparison point.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default-parameter stage vector after edge t: bit k high once t >= 16 + 8k.
    function automatic logic [3:0] exp_stage(input int t);
        logic [3:0] v;
        v = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            if (t >= 16 + 8 * k) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic chk_main_zero(input string tag);
        chk({tag, " stage"}, 32'(stage), 32'(0));
        chk({tag, " ready"}, 32'(ready), 32'(0));
        chk({tag, " drain"}, 32'(drain), 32'(0));
        chk({tag, " tmo"},   32'(tmo),   32'(0));
    endtask

    // Walk the release sequence from edge t=from to t=upto.
    task automatic run_seq(input int from, input int upto, input bit with_c);
        for (int t = from; t <= upto; t++) begin
            tick();
            chk($sformatf("stage t=%0d", t), 32'(stage), 32'(exp_stage(t)));
            chk($sformatf("ready t=%0d", t), 32'(ready), 32'(t >= 48));
            chk($sformatf("drain t=%0d", t), 32'(drain), 32'(0));
            chk($sformatf("tmo t=%0d", t),   32'(tmo),   32'(0));
            if (with_c) begin
                chk($sformatf("c stage t=%0d", t), 32'(stage_c), 32'(t >= 1));
                chk($sformatf("c ready t=%0d", t), 32'(ready_c), 32'(t >= 2));
            end
        end
    endtask

    initial begin
        resetn = 1'b0; sw = 1'b0; idle = 1'b0;
        resetn_c = 1'b0; sw_c = 1'b0; idle_c = 1'b0;

        // Power-up reset for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_main_zero("por");
            chk("por c stage", 32'(stage_c), 32'(0));
            chk("por c ready", 32'(ready_c), 32'(0));
        end
        resetn = 1'b1; resetn_c = 1'b1;
        run_seq(0, 49, 1'b1);

        // Reset dropped mid-release
        resetn = 1'b0; tick(); chk_main_zero("rst0");
        resetn = 1'b1;
        run_seq(0, 30, 1'b0);
        resetn = 1'b0; tick(); chk_main_zero("mid");
        resetn = 1'b1;
        run_seq(0, 49, 1'b0);

        // Soft reset, idle seen on third drain edge
        sw = 1'b1; tick(); sw = 1'b0;
        chk("soft e ready", 32'(ready), 32'(0));
        chk("soft e drain", 32'(drain), 32'(1));
        chk("soft e stage", 32'(stage), 32'(4'hF));
        for (int n = 1; n <= 2; n++) begin
            tick();
            chk($sformatf("soft drain n=%0d", n), 32'(drain), 32'(1));
            chk($sformatf("soft stage n=%0d", n), 32'(stage), 32'(4'hF));
        end
        idle = 1'b1; tick(); idle = 1'b0;
        chk_main_zero("soft drop");
        run_seq(1, 49, 1'b0);

        // Drain timeout with idle held low
        sw = 1'b1; tick(); sw = 1'b0;
        chk("to e drain", 32'(drain), 32'(1));
        for (int n = 1; n <= 255; n++) begin
            tick();
            chk($sformatf("to drain n=%0d", n), 32'(drain), 32'(1));
            chk($sformatf("to tmo n=%0d", n),   32'(tmo),   32'(0));
        end
        tick();
        chk("to edge stage", 32'(stage), 32'(0));
        chk("to edge drain", 32'(drain), 32'(0));
        chk("to edge tmo",   32'(tmo),   32'(1));
        run_seq(1, 49, 1'b0);

        // Request held through HOLD/RELEASE only is ignored
        resetn = 1'b0; tick(); chk_main_zero("ign rst");
        resetn = 1'b1; sw = 1'b1;
        run_seq(0, 47, 1'b0);
        sw = 1'b0;
        run_seq(48, 55, 1'b0);

        // Minimum parameters: idle exactly at the timeout edge
        sw_c = 1'b1; tick(); sw_c = 1'b0;
        chk("c e drain", 32'(drain_c), 32'(1));
        chk("c e ready", 32'(ready_c), 32'(0));
        chk("c e stage", 32'(stage_c), 32'(1));
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk($sformatf("c drain n=%0d", n), 32'(drain_c), 32'(1));
            chk($sformatf("c tmo n=%0d", n),   32'(tmo_c),   32'(0));
        end
        idle_c = 1'b1; tick(); idle_c = 1'b0;
        chk("c idle stage", 32'(stage_c), 32'(0));
        chk("c idle drain", 32'(drain_c), 32'(0));
        chk("c idle tmo",   32'(tmo_c),   32'(0));
        tick();
        chk("c idle t1 stage", 32'(stage_c), 32'(1));
        chk("c idle t1 ready", 32'(ready_c), 32'(0));
        tick();
        chk("c idle t2 ready", 32'(ready_c), 32'(1));

        // Minimum parameters: real timeout, one-cycle pulse
        sw_c = 1'b1; tick(); sw_c = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk($sformatf("c2 drain n=%0d", n), 32'(drain_c), 32'(1));
        end
        tick();
        chk("c2 to stage", 32'(stage_c), 32'(0));
        chk("c2 to tmo",   32'(tmo_c),   32'(1));
        tick();
        chk("c2 t1 tmo",   32'(tmo_c),   32'(0));
        chk("c2 t1 stage", 32'(stage_c), 32'(1));
        tick();
        chk("c2 t2 ready", 32'(ready_c), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
